// File: rtl/cronometro_lap.sv
// cronometro_lap: BCD stopwatch/timer with a built-in tick prescaler,
// count-up/count-down modes, clamped preset loading and lap capture.
//
// Parameters
//   TICK_DIV  clk cycles per counted second (>= 1)
//   H_MAX     maximum hour value (0..9)
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   enable                     run when high, hold prescaler and digits when low
//   mode                       0 = count up, 1 = count down
//   load, ld_s0..ld_h          one-cycle preset strobe and preset digits
//   lap                        one-cycle lap-capture strobe
//   s0, s1, m0, m1, h          live BCD time
//   lap_s0..lap_h, lap_valid   captured lap time and capture flag
//   wrap                       one-cycle pulse on up-count rollover
//   done                       sticky down-count-finished flag
module cronometro_lap #(
  parameter int TICK_DIV = 50000000,
  parameter int H_MAX    = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       mode,
  input  logic       load,
  input  logic [3:0] ld_s0,
  input  logic [3:0] ld_s1,
  input  logic [3:0] ld_m0,
  input  logic [3:0] ld_m1,
  input  logic [3:0] ld_h,
  input  logic       lap,
  output logic [3:0] s0,
  output logic [3:0] s1,
  output logic [3:0] m0,
  output logic [3:0] m1,
  output logic [3:0] h,
  output logic [3:0] lap_s0,
  output logic [3:0] lap_s1,
  output logic [3:0] lap_m0,
  output logic [3:0] lap_m1,
  output logic [3:0] lap_h,
  output logic       lap_valid,
  output logic       wrap,
  output logic       done
);

  localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]      HMAX       = 4'(H_MAX);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    s0_q, s1_q, m0_q, m1_q, h_q;
  logic [3:0]    s0_d, s1_d, m0_d, m1_d, h_d;
  logic [3:0]    ls0_q, ls1_q, lm0_q, lm1_q, lh_q;
  logic [3:0]    ls0_d, ls1_d, lm0_d, lm1_d, lh_d;
  logic          lap_valid_q, lap_valid_d;
  logic          wrap_q, wrap_d;
  logic          done_q, done_d;

  logic at_zero, at_one, at_max, frozen, tick;

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  assign at_zero = (h_q == 4'd0) && (m1_q == 4'd0) && (m0_q == 4'd0) &&
                   (s1_q == 4'd0) && (s0_q == 4'd0);
  assign at_one  = (h_q == 4'd0) && (m1_q == 4'd0) && (m0_q == 4'd0) &&
                   (s1_q == 4'd0) && (s0_q == 4'd1);
  assign at_max  = (h_q == HMAX) && (m1_q == 4'd5) && (m0_q == 4'd9) &&
                   (s1_q == 4'd5) && (s0_q == 4'd9);

  // Down mode sitting at zero suppresses both the prescaler and the tick.
  assign frozen = mode && at_zero;
  assign tick   = enable && !frozen && (presc_q == PRESC_LAST);

  always_comb begin
    presc_d     = presc_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    m0_d        = m0_q;
    m1_d        = m1_q;
    h_d         = h_q;
    ls0_d       = ls0_q;
    ls1_d       = ls1_q;
    lm0_d       = lm0_q;
    lm1_d       = lm1_q;
    lh_d        = lh_q;
    lap_valid_d = lap_valid_q | lap;
    wrap_d      = 1'b0;
    done_d      = done_q && mode;

    // Lap samples the pre-update time, independent of load/tick.
    if (lap) begin
      ls0_d = s0_q;
      ls1_d = s1_q;
      lm0_d = m0_q;
      lm1_d = m1_q;
      lh_d  = h_q;
    end

    if (load) begin
      s0_d    = clamp(ld_s0, 4'd9);
      s1_d    = clamp(ld_s1, 4'd5);
      m0_d    = clamp(ld_m0, 4'd9);
      m1_d    = clamp(ld_m1, 4'd5);
      h_d     = clamp(ld_h, HMAX);
      presc_d = '0;
      done_d  = 1'b0;
    end else begin
      if (enable && !frozen) begin
        presc_d = tick ? '0 : presc_q + PW'(1);
      end
      if (tick && !mode) begin
        wrap_d = at_max;
        if (s0_q != 4'd9) begin
          s0_d = s0_q + 4'd1;
        end else begin
          s0_d = '0;
          if (s1_q != 4'd5) begin
            s1_d = s1_q + 4'd1;
          end else begin
            s1_d = '0;
            if (m0_q != 4'd9) begin
              m0_d = m0_q + 4'd1;
            end else begin
              m0_d = '0;
              if (m1_q != 4'd5) begin
                m1_d = m1_q + 4'd1;
              end else begin
                m1_d = '0;
                h_d  = (h_q == HMAX) ? 4'd0 : h_q + 4'd1;
              end
            end
          end
        end
      end else if (tick && mode) begin
        // Not frozen, so a borrow out of m1 always finds a nonzero hour.
        done_d = done_d | at_one;
        if (s0_q != 4'd0) begin
          s0_d = s0_q - 4'd1;
        end else begin
          s0_d = 4'd9;
          if (s1_q != 4'd0) begin
            s1_d = s1_q - 4'd1;
          end else begin
            s1_d = 4'd5;
            if (m0_q != 4'd0) begin
              m0_d = m0_q - 4'd1;
            end else begin
              m0_d = 4'd9;
              if (m1_q != 4'd0) begin
                m1_d = m1_q - 4'd1;
              end else begin
                m1_d = 4'd5;
                h_d  = h_q - 4'd1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      s0_q        <= '0;
      s1_q        <= '0;
      m0_q        <= '0;
      m1_q        <= '0;
      h_q         <= '0;
      ls0_q       <= '0;
      ls1_q       <= '0;
      lm0_q       <= '0;
      lm1_q       <= '0;
      lh_q        <= '0;
      lap_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      m0_q        <= m0_d;
      m1_q        <= m1_d;
      h_q         <= h_d;
      ls0_q       <= ls0_d;
      ls1_q       <= ls1_d;
      lm0_q       <= lm0_d;
      lm1_q       <= lm1_d;
      lh_q        <= lh_d;
      lap_valid_q <= lap_valid_d;
      wrap_q      <= wrap_d;
      done_q      <= done_d;
    end
  end

  assign s0        = s0_q;
  assign s1        = s1_q;
  assign m0        = m0_q;
  assign m1        = m1_q;
  assign h         = h_q;
  assign lap_s0    = ls0_q;
  assign lap_s1    = ls1_q;
  assign lap_m0    = lm0_q;
  assign lap_m1    = lm1_q;
  assign lap_h     = lh_q;
  assign lap_valid = lap_valid_q;
  assign wrap      = wrap_q;
  assign done      = done_q;

endmodule

// File: tb/tb_cronometro_lap.sv
`timescale 1ns/1ps
module tb_cronometro_lap;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, enable = 1'b0, mode = 1'b0, load = 1'b0, lap = 1'b0;
  logic [3:0] ld_s0 = '0, ld_s1 = '0, ld_m0 = '0, ld_m1 = '0, ld_h = '0;

  // Instance 0: TICK_DIV=3, H_MAX=3.  Instance 1: TICK_DIV=1, H_MAX=9.
  logic [1:0][19:0] live, lapd;
  logic [1:0]       lvo, wro, dno;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [3:0] s0, s1, m0, m1, h, l0, l1, l2, l3, l4;
    logic       lv, wr, dn;
    cronometro_lap #(.TICK_DIV(g == 0 ? 3 : 1), .H_MAX(g == 0 ? 3 : 9)) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode), .load(load),
      .ld_s0(ld_s0), .ld_s1(ld_s1), .ld_m0(ld_m0), .ld_m1(ld_m1), .ld_h(ld_h),
      .lap(lap),
      .s0(s0), .s1(s1), .m0(m0), .m1(m1), .h(h),
      .lap_s0(l0), .lap_s1(l1), .lap_m0(l2), .lap_m1(l3), .lap_h(l4),
      .lap_valid(lv), .wrap(wr), .done(dn)
    );
    assign live[g] = {h, m1, m0, s1, s0};
    assign lapd[g] = {l4, l3, l2, l1, l0};
    assign lvo[g]  = lv;
    assign wro[g]  = wr;
    assign dno[g]  = dn;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: time kept as total seconds, prescaler as an integer.
  int TD[2] = '{3, 1};
  int HM[2] = '{3, 9};
  int mt[2] = '{0, 0}, mp[2] = '{0, 0}, mlt[2] = '{0, 0};
  bit mlv[2], mwr[2], mdn[2];

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [19:0] dig(input int t);
    int s, m, hh;
    s  = t % 60;
    m  = (t / 60) % 60;
    hh = t / 3600;
    return {4'(hh), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      bit frz, tk;
      if (reset) begin
        mt[g] = 0; mp[g] = 0; mlt[g] = 0; mlv[g] = 0; mwr[g] = 0; mdn[g] = 0;
      end else begin
        if (lap) begin mlt[g] = mt[g]; mlv[g] = 1; end
        frz = mode && (mt[g] == 0);
        tk  = enable && !frz && (mp[g] == TD[g] - 1);
        mwr[g] = 0;
        if (!mode) mdn[g] = 0;
        if (load) begin
          mt[g] = mn(int'(ld_h), HM[g]) * 3600
                + (mn(int'(ld_m1), 5) * 10 + mn(int'(ld_m0), 9)) * 60
                + mn(int'(ld_s1), 5) * 10 + mn(int'(ld_s0), 9);
          mp[g] = 0;
          mdn[g] = 0;
        end else begin
          if (enable && !frz) mp[g] = tk ? 0 : mp[g] + 1;
          if (tk) begin
            if (!mode) begin
              if (mt[g] == HM[g] * 3600 + 3599) begin mt[g] = 0; mwr[g] = 1; end
              else mt[g] = mt[g] + 1;
            end else begin
              mt[g] = mt[g] - 1;
              if (mt[g] == 0) mdn[g] = 1;
            end
          end
        end
      end
    end
  end

  bit cmp_on = 0;
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("model_live%0d", g), 32'(live[g]), 32'(dig(mt[g])));
        chk($sformatf("model_lap%0d", g), 32'(lapd[g]), 32'(dig(mlt[g])));
        chk($sformatf("model_flags%0d", g), {29'd0, lvo[g], wro[g], dno[g]},
            {29'd0, mlv[g], mwr[g], mdn[g]});
      end
    end
  end

  task automatic do_load(input logic [3:0] a, b, c, d, e);
    ld_s0 = a; ld_s1 = b; ld_m0 = c; ld_m1 = d; ld_h = e;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; mode = 1'b0;
    @(negedge clk);
    cmp_on = 1;
    repeat (2) @(negedge clk);
    chk("reset_live0", 32'(live[0]), 32'h0);
    chk("reset_flags0", {29'd0, lvo[0], wro[0], dno[0]}, 32'h0);

    // First tick latency from reset release.
    reset = 1'b0;
    @(negedge clk);
    chk("lat_dut1_e1", 32'(live[1]), 32'h00001);
    chk("lat_dut0_e1", 32'(live[0]), 32'h0);
    @(negedge clk);
    chk("lat_dut0_e2", 32'(live[0]), 32'h0);
    @(negedge clk);
    chk("lat_dut0_e3", 32'(live[0]), 32'h00001);
    repeat (177) @(negedge clk);
    chk("carry_dut0_180", 32'(live[0]), 32'h00100);
    chk("carry_dut1_180", 32'(live[1]), 32'h00300);

    // Clamp of over-range preset digits.
    enable = 1'b0;
    do_load(4'd0, 4'd7, 4'd12, 4'd5, 4'd9);
    chk("clamp_dut0", 32'(live[0]), 32'h35950);
    chk("clamp_dut1", 32'(live[1]), 32'h95950);

    // Lap coincident with a tick, then a second lap.
    do_load(4'd7, 4'd0, 4'd0, 4'd0, 4'd0);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    chk("lap1_lap0", 32'(lapd[0]), 32'h00007);
    chk("lap1_live0", 32'(live[0]), 32'h00008);
    chk("lap1_valid0", 32'(lvo[0]), 32'h1);
    chk("lap1_lap1", 32'(lapd[1]), 32'h00009);
    repeat (3) @(negedge clk);
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    chk("lap2_lap0", 32'(lapd[0]), 32'h00009);
    chk("lap2_lap1", 32'(lapd[1]), 32'h00013);

    // Up rollover with wrap pulse.
    enable = 1'b0;
    do_load(4'd9, 4'd5, 4'd9, 4'd5, 4'd9);
    chk("roll_pre0", 32'(live[0]), 32'h35959);
    enable = 1'b1;
    @(negedge clk);
    chk("roll_live1", 32'(live[1]), 32'h0);
    chk("roll_wrap1_hi", 32'(wro[1]), 32'h1);
    chk("roll_wrap0_lo", 32'(wro[0]), 32'h0);
    @(negedge clk);
    chk("roll_wrap1_gone", 32'(wro[1]), 32'h0);
    @(negedge clk);
    chk("roll_live0", 32'(live[0]), 32'h0);
    chk("roll_wrap0_hi", 32'(wro[0]), 32'h1);
    @(negedge clk);
    chk("roll_wrap0_gone", 32'(wro[0]), 32'h0);

    // Down count to zero, hold, and done cleared by load.
    enable = 1'b0;
    mode = 1'b1;
    do_load(4'd1, 4'd0, 4'd1, 4'd0, 4'd0);
    chk("down_done_clr", 32'(dno[0]), 32'h0);
    enable = 1'b1;
    repeat (182) @(negedge clk);
    chk("down_182_live0", 32'(live[0]), 32'h00001);
    chk("down_182_done0", 32'(dno[0]), 32'h0);
    @(negedge clk);
    chk("down_183_live0", 32'(live[0]), 32'h0);
    chk("down_183_done0", 32'(dno[0]), 32'h1);
    repeat (10) @(negedge clk);
    chk("down_hold_live0", 32'(live[0]), 32'h0);
    chk("down_hold_done0", 32'(dno[0]), 32'h1);
    chk("down_hold_done1", 32'(dno[1]), 32'h1);
    do_load(4'd5, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("down_reload_done0", 32'(dno[0]), 32'h0);
    chk("down_reload_live0", 32'(live[0]), 32'h00005);

    // Enable gap delays the tick by exactly its length.
    mode = 1'b0;
    enable = 1'b0;
    do_load(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("gap_e7", 32'(live[0]), 32'h0);
    @(negedge clk);
    chk("gap_e8", 32'(live[0]), 32'h00001);

    // Reset wins over load and lap.
    reset = 1'b1; load = 1'b1; lap = 1'b1;
    ld_s0 = 4'd9; ld_s1 = 4'd5; ld_m0 = 4'd9; ld_m1 = 4'd5; ld_h = 4'd9;
    @(negedge clk);
    reset = 1'b0; load = 1'b0; lap = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_live%0d", g), 32'(live[g]), 32'h0);
      chk($sformatf("rst_lap%0d", g), 32'(lapd[g]), 32'h0);
      chk($sformatf("rst_flags%0d", g), {29'd0, lvo[g], wro[g], dno[g]}, 32'h0);
    end

    // Randomized phase against the model.
    repeat (4000) begin
      @(negedge clk);
      reset  = ($urandom_range(0, 499) == 0);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 149) == 0) mode = ~mode;
      load = ($urandom_range(0, 59) == 0);
      if (load) begin
        case ($urandom_range(0, 2))
          0: begin
            ld_s0 = 4'($urandom_range(0, 15)); ld_s1 = 4'($urandom_range(0, 1));
            ld_m0 = '0; ld_m1 = '0; ld_h = '0;
          end
          1: begin
            ld_s0 = 4'($urandom_range(5, 9)); ld_s1 = 4'd5; ld_m0 = 4'd9;
            ld_m1 = 4'd5; ld_h = 4'($urandom_range(2, 15));
          end
          default: begin
            ld_s0 = 4'($urandom); ld_s1 = 4'($urandom); ld_m0 = 4'($urandom);
            ld_m1 = 4'($urandom); ld_h = 4'($urandom);
          end
        endcase
      end
      lap = ($urandom_range(0, 19) == 0);
    end
    @(negedge clk);
    reset = 1'b0; load = 1'b0; lap = 1'b0;
    repeat (5) @(negedge clk);
    cmp_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cronometro_lap.md
# cronometro_lap

Parametrised BCD stopwatch/timer that succeeds the fixed up-counting stopwatch. It adds a built-in tick prescaler, a configurable hour range, count-up and count-down modes, preset loading and lap (split) capture. It drives the same five BCD digit outputs (s0, s1, m0, m1, h) consumed by the VGA digit renderer, plus lap digits and status flags for the display/control logic.

## Interface
Parameters:
- TICK_DIV, 50000000: clk cycles per counted second; legal range ≥1.
- H_MAX, 9: maximum hour value, 0..9.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  run when high; hold (prescaler and digits) when low.
- mode  in  1  0 = count up, 1 = count down.
- load  in  1  one-cycle preset strobe.
- ld_s0, ld_s1, ld_m0, ld_m1, ld_h  in  4 each  preset digits.
- lap  in  1  one-cycle lap-capture strobe.
- s0, s1, m0, m1, h  out  4 each  live BCD time: seconds units/tens, minutes units/tens, hours.
- lap_s0, lap_s1, lap_m0, lap_m1, lap_h  out  4 each  captured lap time.
- lap_valid  out  1  high once a lap has been captured.
- wrap  out  1  one-cycle pulse on up-count rollover.
- done  out  1  sticky down-count-finished flag.

## Operation
- Digit ranges: s0 0..9, s1 0..5, m0 0..9, m1 0..5, h 0..H_MAX.
- Prescaler: counter 0..TICK_DIV-1, advances only while enable=1 and not frozen. Internal tick = enable & (presc == TICK_DIV-1) & !frozen. The counter returns to 0 on tick. TICK_DIV=1 ticks every enabled cycle.
- frozen = mode & (time == 0:00:00).
- Up count on tick: s0+1. On 9→0 carry into s1. On s1 5→0 carry into m0, then m1 (5→0), then h.
- Up rollover: at H_MAX:59:59 a tick gives 0:00:00 and pulses wrap for 1 cycle.
- Down count on tick: s0-1 with borrow chain (s0 0→9, s1 0→5, m0 0→9, m1 0→5, h-1).
- Down finish: the tick that reaches 0:00:00 sets done. While frozen, ticks are suppressed and the time holds at zero.
- done clears on reset, on load, or when mode goes to 0. It never sets in up mode.
- load: copies ld_* into the live digits. Each digit above its range is clamped to its max (e.g. ld_s1=7→5, ld_h>H_MAX→H_MAX). load also clears the prescaler and done.
- lap: copies the current live digits (pre-update values of this cycle) into lap_* and sets lap_valid. lap_valid stays high until reset; later laps overwrite lap_*.
- Priority per cycle: reset > load > tick. lap is independent, so lap and load in the same cycle captures the pre-load time.
- mode may change at any time. The next tick uses the new direction; the prescaler is not cleared.
- Combinational ld_* values out of BCD range (A..F) clamp like any over-range value.

## Timing
- All outputs are registered and update on the rising clk edge.
- Reset: all digits, lap digits, prescaler, lap_valid, wrap and done are 0.
- Latency: digits change on the edge that samples tick. From reset release with enable=1 held, the first change appears after exactly TICK_DIV edges.
- load and lap take effect 1 edge after the strobe is sampled.
- wrap is high for the single cycle following the rollover edge. done is high from the finishing edge onward.
- enable low for N cycles delays the next tick by exactly N cycles, because the prescaler holds its value.
- reset asserted mid-count takes effect on the next edge regardless of any other input.

## Test plan
- Up count, TICK_DIV=2, H_MAX=9, enable=1 from reset → s0=1 after 2 edges; 0:00:59→0:01:00 carry; after 120 ticks the time reads 0:02:00.
- Up rollover, H_MAX=1: load 1:59:58, run 2 ticks → 1:59:59, then 0:00:00 with wrap high for exactly 1 cycle.
- Down mode: load 0:01:01 with mode=1, run 61 ticks → 0:00:00 and done=1; further cycles hold zero; load 0:00:05 clears done.
- Clamp: load ld_s1=7, ld_m0=12, ld_h=9 with H_MAX=3 → s1=5, m0=9, h=3.
- Lap: at 0:00:07, lap in the same cycle as a tick → lap_s0=7, live s0=8, lap_valid=1. A second lap at 0:00:09 → lap_s0=9.
- Enable/reset: deassert enable for 5 cycles mid-count → tick delayed by exactly 5 cycles. Assert reset during load → all outputs 0 on the next edge.
